period_meter: RTL and testbench

- Measures a slow square-wave input, such as the output of the team's clock divider, in cycles of the fast system clock.
- Reports the full period and the high time of each complete cycle, plus a one-cycle valid strobe.
- Flags a timeout when the input stops toggling.
- Used by the lock's self-test path to confirm the divided timing tick and its ~50% duty cycle.

---
 rtl/period_meter.sv | 143 ++++++++++++++
 tb/tb_period_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter
//
// Measures a slow square wave (sig_in) in cycles of the fast system clock.
// Every complete input cycle (rising edge to rising edge) produces a
// one-cycle meas_valid pulse with the full period and the high time. If the
// input stops toggling for MAX_COUNT cycles after an armed rising edge, the
// sticky timeout flag is raised and the meter re-arms on the next rise.
//
// Ports:
//   clk         system clock, the only clock
//   rst         asynchronous, active-high reset
//   sig_in      slow signal under test, asynchronous to clk
//   period_out  cycles between the last two rising edges of sig_in
//   high_out    cycles sig_in was high within that period
//   meas_valid  one-cycle pulse, period_out/high_out updated this cycle
//   timeout     sticky stall flag, cleared by the next valid measurement
module period_meter #(
    parameter int unsigned W         = 32,
    parameter int unsigned MAX_COUNT = 200000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] high_out,
    output logic         meas_valid,
    output logic         timeout
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [W-1:0] MAX_C = W'(MAX_COUNT);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] ZERO  = '0;

    // Three-flop chain: s1/s2 resolve metastability, s3 gives the previous
    // value of s2 so both edges see the same two-cycle delay.
    logic s1_q;
    logic s2_q;
    logic s3_q;

    logic rise;
    logic fall;

    state_t       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] hi_latch_q;

    // Detect-stage results, transferred to the ports one edge later so the
    // outputs, the valid strobe and the timeout clear all change together.
    logic [W-1:0] per_q;
    logic [W-1:0] high_q;
    logic         valid_q;
    logic         to_q;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= ZERO;
            hi_latch_q <= ZERO;
            per_q      <= ZERO;
            high_q     <= ZERO;
            valid_q    <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Not counting while idle: a stuck input only times out
                    // once it has been armed by a rising edge.
                    cnt_q      <= ZERO;
                    hi_latch_q <= ZERO;
                    if (rise) begin
                        cnt_q   <= ONE;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        per_q   <= cnt_q;
                        high_q  <= hi_latch_q;
                        valid_q <= 1'b1;
                        to_q    <= 1'b0;
                        cnt_q   <= ONE;
                    end else if (fall) begin
                        hi_latch_q <= cnt_q;
                        // Saturate so a fall landing exactly on MAX_COUNT
                        // cannot wrap the counter; the stall check fires on
                        // the following cycle instead.
                        if (cnt_q >= MAX_C) begin
                            cnt_q <= cnt_q;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end else if (cnt_q >= MAX_C) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= ZERO;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_out <= ZERO;
            high_out   <= ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            period_out <= per_q;
            high_out   <= high_q;
            meas_valid <= valid_q;
            timeout    <= to_q;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter. The stimulus process drives sig_in one clk
// sample at a time and feeds the same samples to a reference model that
// works on sample indices of rising and falling edges. Completed periods are
// queued as expected measurements; a monitor pops and compares them whenever
// the DUT raises meas_valid.
module tb_period_meter;

    localparam int MAXC = 20;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        meas_valid;
    logic        timeout;

    period_meter #(
        .W         (32),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned p;
        int unsigned h;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state (sample-index based).
    int k     = 0;
    bit prev  = 1'b0;
    bit armed = 1'b0;
    int t0    = 0;
    int tf    = 0;
    bit mto   = 1'b0;

    int unsigned last_p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // One clk sample of sig_in, applied to both the DUT and the model.
    task automatic step(input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        sig_in = v;
        k++;
        if (v && !prev) begin
            if (armed) begin
                e.p = k - t0;
                e.h = tf - t0;
                exp_q.push_back(e);
                mto = 1'b0;
            end
            armed = 1'b1;
            t0    = k;
        end else if (!v && prev) begin
            tf = k;
        end else if (armed && (k - t0) >= MAXC) begin
            mto   = 1'b1;
            armed = 1'b0;
        end
        prev = v;
    endtask

    task automatic pulse(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    // Asynchronous one-cycle reset in the middle of a clk low phase.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_period"},  period_out, 32'd0);
        chk({tag, "_high"},    high_out,   32'd0);
        chk({tag, "_valid"},   {31'd0, meas_valid}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout},    32'd0);
        @(negedge clk);
        rst    = 1'b0;
        sig_in = 1'b0;
        exp_q.delete();
        prev  = 1'b0;
        armed = 1'b0;
        mto   = 1'b0;
    endtask

    // Monitor: compares every DUT measurement against the scoreboard.
    initial begin
        bit   pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                chk("valid_one_cycle", {31'd0, pv}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got period=%0d high=%0d expected no measurement",
                             period_out, high_out);
                end else begin
                    e = exp_q.pop_front();
                    last_p = e.p;
                    $display("meas period=%0d high=%0d (want %0d/%0d) timeout=%0b",
                             period_out, high_out, e.p, e.h, timeout);
                    chk("period", period_out, e.p);
                    chk("high", high_out, e.h);
                    chk("timeout_at_valid", {31'd0, timeout}, 32'd0);
                end
            end
            pv = meas_valid;
        end
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_period",  period_out, 32'd0);
        chk("reset_high",    high_out,   32'd0);
        chk("reset_valid",   {31'd0, meas_valid}, 32'd0);
        chk("reset_timeout", {31'd0, timeout},    32'd0);
        rst = 1'b0;

        // Held low from reset: idle never counts, so no timeout.
        repeat (50) step(1'b0);
        chk("idle_no_timeout", {31'd0, timeout}, {31'd0, mto});

        // Divider n=4.
        repeat (8) pulse(4, 4);
        chk("div4_timeout", {31'd0, timeout}, {31'd0, mto});

        // 3 high / 7 low.
        repeat (6) pulse(3, 7);

        // 1-clk-wide pulses every 5 clk.
        repeat (8) pulse(1, 4);

        // Stall while high, then recover.
        repeat (4) pulse(4, 4);
        repeat (40) step(1'b1);
        chk("stall_timeout", {31'd0, timeout}, {31'd0, mto});
        chk("stall_period_kept", period_out, last_p);
        chk("stall_period_8", period_out, 32'd8);
        repeat (4) step(1'b1);
        repeat (4) step(1'b0);
        pulse(4, 4);
        chk("rearmed_still_timeout", {31'd0, timeout}, {31'd0, mto});
        repeat (3) pulse(4, 4);
        repeat (6) step(1'b0);
        chk("recovered_timeout", {31'd0, timeout}, {31'd0, mto});

        // Reset in the middle of a high phase.
        repeat (3) pulse(4, 4);
        repeat (2) step(1'b1);
        do_reset("midrst");
        repeat (4) pulse(4, 4);

        // Randomized high/low lengths, some long enough to stall.
        for (int i = 0; i < 60; i++) begin
            int h;
            int l;
            h = int'($urandom_range(12, 1));
            l = int'($urandom_range(12, 1));
            if ($urandom_range(9, 0) == 0) l = l + 15;
            pulse(h, l);
        end
        repeat (45) step(1'b0);
        chk("final_timeout", {31'd0, timeout}, {31'd0, mto});
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
